// File: rtl/adc_frame_buffer_pkg.sv
// fft_pkg: shared frame-buffer constants, sample type and bit-reverse helper.
package fft_pkg;
  localparam int FFT_N = 64;
  localparam int LOG2_N = $clog2(FFT_N);
  localparam int ADC_BITS = 12;
  localparam int OUT_W = 16;
  typedef logic signed [OUT_W-1:0] sample_t;
  function automatic logic [8:0] bitrev(input logic [8:0] a, input int n);
    logic [8:0] r;
    logic [8:0] s;
    r = '0;
    s = a;
    for (int i = 0; i < 9; i++) begin
      if (i < n) begin
        r = {r[7:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/adc_frame_buffer_sample_ram.sv
// sample_ram: simple dual-port RAM, one write port and one enabled, registered read port.
module sample_ram #(
  parameter int AW = 7,
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: captures ADC words into a bit-reversed ping-pong frame RAM for the FFT.
module adc_frame_buffer
  import fft_pkg::*;
#(
  parameter int FFT_N = fft_pkg::FFT_N,
  parameter int ADC_BITS = fft_pkg::ADC_BITS,
  parameter int OUT_W = fft_pkg::OUT_W,
  localparam int LG = $clog2(FFT_N)
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [15:0]             SAMPLE_IN,
  input  logic                    SAMPLE_DV,
  input  logic                    RD_EN,
  input  logic [LG-1:0]           RD_ADDR,
  output logic signed [OUT_W-1:0] RD_DATA,
  output logic                    FRAME_RDY,
  input  logic                    FRAME_DONE,
  output logic                    OVERRUN,
  input  logic                    CLR_OVERRUN
);
  logic r_dv_d, r_arm, r_wr_bank, r_rd_bank, r_ovr, r_seen;
  logic [1:0] r_full, w_full_nxt;
  logic [LG-1:0] r_wr_ptr, w_wr_idx;
  logic w_ev, w_drop, w_we, w_last, w_rel, w_unused;
  logic signed [ADC_BITS-1:0] w_raw;
  logic signed [OUT_W-1:0] w_s, w_q;
  assign w_unused = ^SAMPLE_IN[15:ADC_BITS];
  assign w_raw = {~SAMPLE_IN[ADC_BITS-1], SAMPLE_IN[ADC_BITS-2:0]};
  assign w_s = OUT_W'(w_raw);
  // r_arm masks the first cycle after reset so a DV already high is not taken as an edge
  assign w_ev = SAMPLE_DV & ~r_dv_d & r_arm;
  assign w_drop = w_ev & r_full[r_wr_bank];
  assign w_we = w_ev & ~r_full[r_wr_bank];
  assign w_last = r_wr_ptr == LG'(FFT_N - 1);
  assign w_rel = FRAME_DONE & r_full[r_rd_bank];
  assign w_wr_idx = LG'(bitrev(9'(r_wr_ptr), LG));
  always_comb begin
    w_full_nxt = r_full;
    if (w_we && w_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rel) w_full_nxt[r_rd_bank] = 1'b0;
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_dv_d <= 1'b0;
      r_arm <= 1'b0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_ptr <= '0;
      r_full <= '0;
      r_ovr <= 1'b0;
      r_seen <= 1'b0;
    end else begin
      r_dv_d <= SAMPLE_DV;
      r_arm <= 1'b1;
      r_full <= w_full_nxt;
      if (w_we) begin
        r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
        if (w_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_rel) r_rd_bank <= ~r_rd_bank;
      r_ovr <= w_drop | (r_ovr & ~CLR_OVERRUN);
      r_seen <= r_seen | RD_EN;
    end
  end
  sample_ram #(.AW(LG + 1), .W(OUT_W)) u_ram (
    .clk(CLOCK),
    .i_we(w_we),
    .i_waddr({r_wr_bank, w_wr_idx}),
    .i_wdata(w_s),
    .i_re(RD_EN),
    .i_raddr({r_rd_bank, RD_ADDR}),
    .o_rdata(w_q)
  );
  // BRAM output has no reset; RD_DATA reads as zero until the first read after reset
  assign RD_DATA = r_seen ? w_q : '0;
  assign FRAME_RDY = r_full[r_rd_bank];
  assign OVERRUN = r_ovr;
endmodule
